// File: rtl/ready_skid_reg.sv
// ready_skid_reg
//   Two-entry skid buffer for a valid/ready stream. Both the forward
//   (valid/data) and backward (ready) directions are registered, so there is
//   no combinational path from any input to any output. This lets a long
//   out_ready -> in_ready timing path be cut while still sustaining one beat
//   per cycle.
//
// Ports
//   clk        in   1           clock, all logic on the rising edge
//   rst        in   1           synchronous reset, active-high
//   in_valid   in   1           upstream beat valid
//   in_ready   out  1           upstream ready, straight from a flop
//   in_data    in   DATA_WIDTH  upstream payload
//   out_valid  out  1           downstream beat valid, straight from a flop
//   out_ready  in   1           downstream ready
//   out_data   out  DATA_WIDTH  downstream payload, straight from the main flop
//   occupancy  out  2           beats currently held (0, 1 or 2)

module ready_skid_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;
  logic [1:0]            occ_q, occ_d;

  logic in_fire;
  logic out_fire;

  // Handshakes are qualified with the registered outputs, never with any
  // combinational decode, so the ready path stays flop-to-flop.
  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          // Pass-through: the departing beat is replaced in the same cycle.
          main_d = in_data;
        end else if (in_fire) begin
          // Downstream stalled: park the new beat behind the main entry.
          skid_d  = in_data;
          state_d = ST_FULL;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so in_valid cannot fire.
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Output flops are loaded from the next state so they always agree with
    // state_q after the edge.
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
    case (state_d)
      ST_BUSY: occ_d = 2'd1;
      ST_FULL: occ_d = 2'd2;
      default: occ_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      occ_q       <= occ_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = occ_q;

endmodule
